// File: rtl/cnn_pkg.sv
`default_nettype none
// cnn_pkg: shared state encoding and sizing constants for the convolution pass sequencer.

package cnn_pkg;
  localparam int FILT_LEN = 16;
  localparam int ADDR_W   = 9;
  localparam int IDX_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_FILT = 3'd1,
    S_LOAD_WIN  = 3'd2,
    S_MAC       = 3'd3,
    S_WRITE     = 3'd4,
    S_DONE      = 3'd5
  } state_t;
endpackage

`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// mod_counter: modulus-MOD up counter with enable, synchronous clear and terminal-count flag.

module mod_counter #(
  parameter int MOD = 16,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(MOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_pass_sequencer.sv
`default_nettype none
// conv_pass_sequencer: filter load, window fill, MAC and OFM write scheduler for P PEs.
// Optional stall counter enabled by defining CONV_PASS_SEQ_PERF_EN.

module conv_pass_sequencer
  import cnn_pkg::*;
#(
  parameter int P      = 4,
  parameter int N_WIN  = 8,
  parameter int STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic              mem_rd,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] filt_addr,
  output logic [ADDR_W-1:0] ofm_addr,
  output logic [IDX_W-1:0]  elem_idx,
  output logic              filt_we,
  output logic [P-1:0]      win_we,
  output logic              mac_en,
  output logic              mac_rst,
  output logic              ofm_write,
  output logic [3:0]        ofm_sel,
  output logic [15:0]       stall_cycles
);

  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int WW = $clog2(N_WIN + 1);

  state_t          state;
  logic [WW-1:0]   w;
  logic [IDX_W-1:0] elem_cnt;
  logic [PW-1:0]   p_cnt;
  logic [PW-1:0]   wr_cnt;
  logic            elem_tc;
  logic            p_tc;
  logic            wr_tc;
  logic            job_go;
  logic            acked;

  assign job_go = (state == S_IDLE) && start;
  assign acked  = mem_rd && mem_ack;

  mod_counter #(.MOD(FILT_LEN), .W(IDX_W)) u_elem (
    .clk(clk), .rst_n(rst_n), .clr(job_go),
    .en(acked || (state == S_MAC)),
    .count(elem_cnt), .tc(elem_tc)
  );

  mod_counter #(.MOD(P), .W(PW)) u_pe (
    .clk(clk), .rst_n(rst_n), .clr(job_go),
    .en((state == S_LOAD_WIN) && mem_ack && elem_tc),
    .count(p_cnt), .tc(p_tc)
  );

  mod_counter #(.MOD(P), .W(PW)) u_wr (
    .clk(clk), .rst_n(rst_n), .clr(job_go),
    .en(state == S_WRITE),
    .count(wr_cnt), .tc(wr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      w     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_LOAD_FILT;
          w     <= '0;
        end
        S_LOAD_FILT: if (mem_ack && elem_tc) state <= S_LOAD_WIN;
        S_LOAD_WIN:  if (mem_ack && elem_tc && p_tc) state <= S_MAC;
        S_MAC:       if (elem_tc) state <= S_WRITE;
        S_WRITE: if (wr_tc) begin
          w     <= w + WW'(P);
          state <= (int'(w) + P == N_WIN) ? S_DONE : S_LOAD_WIN;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decodes of registered state/counters; only the buffer write strobes see mem_ack.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign mem_rd    = (state == S_LOAD_FILT) || (state == S_LOAD_WIN);
  assign mac_rst   = (state == S_LOAD_WIN);
  assign mac_en    = (state == S_MAC);
  assign ofm_write = (state == S_WRITE);
  assign elem_idx  = elem_cnt;
  assign filt_addr = (state == S_LOAD_FILT) ? ADDR_W'(elem_cnt) : '0;
  assign ifm_addr  = (state == S_LOAD_WIN)
                   ? ADDR_W'((int'(w) + int'(p_cnt)) * STRIDE + int'(elem_cnt)) : '0;
  assign ofm_addr  = (state == S_WRITE) ? ADDR_W'(int'(w) + int'(wr_cnt)) : '0;
  assign ofm_sel   = (state == S_WRITE) ? 4'(wr_cnt) : '0;
  assign filt_we   = (state == S_LOAD_FILT) && mem_ack;
  assign win_we    = ((state == S_LOAD_WIN) && mem_ack) ? (P'(1) << p_cnt) : '0;

`ifdef CONV_PASS_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (job_go) begin
      stall_cycles <= '0;
    end else if (mem_rd && !mem_ack && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_pass_sequencer.sv
`default_nettype none
// tb_conv_pass_sequencer: randomized self-checking bench with a queue-based address/strobe model.

module tb_conv_pass_sequencer;

  logic clk = 1'b0;
  logic rst_n, start, mem_ack;

  logic [2:0] done_v, busy_v, rd_v, fwe_v, men_v, mrst_v, owr_v;
  logic [8:0] ifm_a [3];
  logic [8:0] filt_a[3];
  logic [8:0] ofm_a [3];
  logic [3:0] elem_a[3];
  logic [3:0] osel_a[3];
  logic [15:0] stall_a[3];
  logic [3:0] ww0, ww1;
  logic [0:0] ww2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_pass_sequencer #(.P(4), .N_WIN(8), .STRIDE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done_v[0]), .busy(busy_v[0]),
    .mem_rd(rd_v[0]), .mem_ack(mem_ack), .ifm_addr(ifm_a[0]), .filt_addr(filt_a[0]),
    .ofm_addr(ofm_a[0]), .elem_idx(elem_a[0]), .filt_we(fwe_v[0]), .win_we(ww0),
    .mac_en(men_v[0]), .mac_rst(mrst_v[0]), .ofm_write(owr_v[0]), .ofm_sel(osel_a[0]),
    .stall_cycles(stall_a[0])
  );

  conv_pass_sequencer #(.P(4), .N_WIN(8), .STRIDE(100)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done_v[1]), .busy(busy_v[1]),
    .mem_rd(rd_v[1]), .mem_ack(mem_ack), .ifm_addr(ifm_a[1]), .filt_addr(filt_a[1]),
    .ofm_addr(ofm_a[1]), .elem_idx(elem_a[1]), .filt_we(fwe_v[1]), .win_we(ww1),
    .mac_en(men_v[1]), .mac_rst(mrst_v[1]), .ofm_write(owr_v[1]), .ofm_sel(osel_a[1]),
    .stall_cycles(stall_a[1])
  );

  conv_pass_sequencer #(.P(1), .N_WIN(2), .STRIDE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done_v[2]), .busy(busy_v[2]),
    .mem_rd(rd_v[2]), .mem_ack(mem_ack), .ifm_addr(ifm_a[2]), .filt_addr(filt_a[2]),
    .ofm_addr(ofm_a[2]), .elem_idx(elem_a[2]), .filt_we(fwe_v[2]), .win_we(ww2),
    .mac_en(men_v[2]), .mac_rst(mrst_v[2]), .ofm_write(owr_v[2]), .ofm_sel(osel_a[2]),
    .stall_cycles(stall_a[2])
  );

  // View of the instance currently under observation.
  int sel = 0;
  int mp = 4, mn = 8, ms = 1;
  logic d_done, d_busy, d_rd, d_fwe, d_men, d_mrst, d_owr;
  logic [8:0] d_ifm, d_filt, d_ofm;
  logic [3:0] d_elem, d_sel, d_wwe;
  logic [15:0] d_stall;
  logic [79:0] d_all;

  always_comb begin
    d_done  = done_v[sel];
    d_busy  = busy_v[sel];
    d_rd    = rd_v[sel];
    d_fwe   = fwe_v[sel];
    d_men   = men_v[sel];
    d_mrst  = mrst_v[sel];
    d_owr   = owr_v[sel];
    d_ifm   = ifm_a[sel];
    d_filt  = filt_a[sel];
    d_ofm   = ofm_a[sel];
    d_elem  = elem_a[sel];
    d_sel   = osel_a[sel];
    d_stall = stall_a[sel];
    case (sel)
      0:       d_wwe = ww0;
      1:       d_wwe = ww1;
      default: d_wwe = {3'b000, ww2};
    endcase
    d_all = {9'd0, d_done, d_busy, d_rd, d_fwe, d_men, d_mrst, d_owr,
             d_ifm, d_filt, d_ofm, d_elem, d_sel, d_stall, d_wwe};
  end

  int done_at, n_filt, n_win, n_mac, n_wr, addr_err, hold_err, wr_err, stall_obs;

  task automatic pick(input int s);
    sel = s;
    mp  = (s == 2) ? 1 : 4;
    mn  = (s == 2) ? 2 : 8;
    ms  = (s == 1) ? 100 : 1;
  endtask

  // mode 0: ack tied high, 1: ack alternates in window fill, 2: random ack,
  // 3: noise on ignored inputs, 4: like 0 but start stays high afterwards.
  task automatic run_job(input int mode);
    int exp_q[$];
    int exp_p[$];
    int a, pe, wr_i;
    bit toggle, prev_stall, ifm_phase;
    logic [8:0] prev_addr, cur_addr;
    for (int e = 0; e < 16; e++) begin exp_q.push_back(e); exp_p.push_back(-1); end
    for (int w = 0; w < mn; w += mp)
      for (int p = 0; p < mp; p++)
        for (int e = 0; e < 16; e++) begin
          exp_q.push_back(((w + p) * ms + e) % 512);
          exp_p.push_back(p);
        end
    done_at = -1; n_filt = 0; n_win = 0; n_mac = 0; n_wr = 0;
    addr_err = 0; hold_err = 0; wr_err = 0; stall_obs = 0;
    toggle = 0; prev_stall = 0; prev_addr = '0; wr_i = 0;
    @(negedge clk);
    start = 1'b1;
    mem_ack = 1'b1;
    for (int cyc = 1; cyc <= 5000; cyc++) begin
      @(negedge clk);
      if (mode != 4) start = (mode == 3 && d_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      ifm_phase = d_mrst;
      case (mode)
        1: if (d_rd && d_mrst) begin mem_ack = toggle; toggle = !toggle; end
           else mem_ack = 1'b1;
        2: mem_ack = 1'($urandom_range(0, 1));
        3: mem_ack = d_rd ? 1'b1 : 1'($urandom_range(0, 1));
        default: mem_ack = 1'b1;
      endcase
      #1;
      cur_addr = ifm_phase ? d_ifm : d_filt;
      if (d_rd && prev_stall && cur_addr !== prev_addr) hold_err++;
      prev_stall = d_rd && !mem_ack;
      prev_addr  = cur_addr;
      if (d_rd && !mem_ack) stall_obs++;
      if (d_rd && mem_ack) begin
        if (exp_q.size() == 0) addr_err++;
        else begin
          a  = exp_q.pop_front();
          pe = exp_p.pop_front();
          if (cur_addr !== 9'(a)) addr_err++;
          if (pe < 0) begin
            if (d_fwe !== 1'b1 || d_wwe !== 4'd0) addr_err++;
          end else if (d_fwe !== 1'b0 || d_wwe !== 4'(1 << pe)) addr_err++;
        end
      end
      if (d_fwe) n_filt++;
      n_win += $countones(d_wwe);
      if (d_men) n_mac++;
      if (d_owr) begin
        if (d_ofm !== 9'(wr_i) || d_sel !== 4'(wr_i % mp)) wr_err++;
        wr_i++;
        n_wr++;
      end
      if (d_done) begin done_at = cyc; break; end
    end
    if (exp_q.size() != 0) addr_err++;
    if (mode != 4) start = 1'b0;
    mem_ack = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0;
    #3;
    for (int s = 0; s < 3; s++) begin
      pick(s);
      #1;
      checks++;
      if (d_all !== 80'd0) begin
        errors++;
        $display("FAIL reset_outputs inst %0d got %h want 0", s, d_all);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal;
    pick(0);
    run_job(0);
    checks++; if (done_at != 185) begin errors++; $display("FAIL nominal_done got %0d want 185", done_at); end
    checks++; if (n_filt != 16)   begin errors++; $display("FAIL nominal_filt_we got %0d want 16", n_filt); end
    checks++; if (n_win != 128)   begin errors++; $display("FAIL nominal_win_we got %0d want 128", n_win); end
    checks++; if (n_mac != 32)    begin errors++; $display("FAIL nominal_mac_en got %0d want 32", n_mac); end
    checks++; if (n_wr != 8 || wr_err != 0) begin errors++; $display("FAIL nominal_ofm got %0d/%0d want 8/0", n_wr, wr_err); end
    checks++; if (addr_err != 0)  begin errors++; $display("FAIL nominal_addr got %0d want 0", addr_err); end
  endtask

  task automatic test_stalls;
    int exp_stall;
    pick(0);
    run_job(1);
`ifdef CONV_PASS_SEQ_PERF_EN
    exp_stall = 128;
`else
    exp_stall = 0;
`endif
    checks++; if (done_at != 185 + 128) begin errors++; $display("FAIL stall_done got %0d want %0d", done_at, 313); end
    checks++; if (hold_err != 0) begin errors++; $display("FAIL stall_addr_hold got %0d want 0", hold_err); end
    checks++; if (addr_err != 0 || n_wr != 8) begin errors++; $display("FAIL stall_seq got %0d/%0d want 0/8", addr_err, n_wr); end
    checks++; if (int'(d_stall) != exp_stall) begin errors++; $display("FAIL stall_counter got %0d want %0d", d_stall, exp_stall); end
  endtask

  task automatic test_random_stalls;
    int exp_stall;
    pick(0);
    for (int r = 0; r < 3; r++) begin
      run_job(2);
`ifdef CONV_PASS_SEQ_PERF_EN
      exp_stall = (stall_obs > 65535) ? 65535 : stall_obs;
`else
      exp_stall = 0;
`endif
      checks++; if (done_at != 185 + stall_obs) begin errors++; $display("FAIL rand_done got %0d want %0d", done_at, 185 + stall_obs); end
      checks++; if (addr_err != 0 || hold_err != 0) begin errors++; $display("FAIL rand_seq got %0d/%0d want 0/0", addr_err, hold_err); end
      checks++; if (int'(d_stall) != exp_stall) begin errors++; $display("FAIL rand_counter got %0d want %0d", d_stall, exp_stall); end
    end
  endtask

  task automatic test_ignored;
    pick(0);
    run_job(3);
    checks++; if (done_at != 185) begin errors++; $display("FAIL ignored_done got %0d want 185", done_at); end
    checks++; if (n_wr != 8 || wr_err != 0) begin errors++; $display("FAIL ignored_writes got %0d/%0d want 8/0", n_wr, wr_err); end
    checks++; if (d_stall !== 16'd0) begin errors++; $display("FAIL ignored_stall_clear got %0d want 0", d_stall); end
  endtask

  task automatic test_wrap;
    pick(1);
    run_job(0);
    checks++; if (addr_err != 0) begin errors++; $display("FAIL wrap_addr got %0d want 0", addr_err); end
    checks++; if (done_at != 185) begin errors++; $display("FAIL wrap_done got %0d want 185", done_at); end
  endtask

  task automatic test_p1;
    pick(2);
    run_job(0);
    checks++; if (done_at != 83) begin errors++; $display("FAIL p1_done got %0d want 83", done_at); end
    checks++; if (n_win != 32) begin errors++; $display("FAIL p1_win_we got %0d want 32", n_win); end
    checks++; if (n_wr != 2 || wr_err != 0 || addr_err != 0) begin errors++; $display("FAIL p1_seq got %0d/%0d/%0d want 2/0/0", n_wr, wr_err, addr_err); end
  endtask

  task automatic test_reset_mid_mac;
    int macs = 0;
    bit saw_done = 0;
    pick(0);
    @(negedge clk);
    start = 1'b1; mem_ack = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (d_done) saw_done = 1;
      if (d_men) macs++;
      if (macs == 8) break;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (macs != 8 || saw_done) begin errors++; $display("FAIL abort_reach_mac got %0d/%0d want 8/0", macs, saw_done); end
    checks++; if (d_all !== 80'd0) begin errors++; $display("FAIL abort_outputs got %h want 0", d_all); end
    @(negedge clk);
    #1;
    checks++; if (d_done !== 1'b0 || d_busy !== 1'b0) begin errors++; $display("FAIL abort_held got %0d%0d want 00", d_done, d_busy); end
    rst_n = 1'b1;
    run_job(0);
    checks++; if (done_at != 185 || n_wr != 8) begin errors++; $display("FAIL abort_rerun got %0d/%0d want 185/8", done_at, n_wr); end
  endtask

  task automatic test_back_to_back;
    int at = -1;
    pick(0);
    run_job(4);
    checks++; if (done_at != 185) begin errors++; $display("FAIL b2b_first got %0d want 185", done_at); end
    @(negedge clk); #1;
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0d want 0", d_busy); end
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++; if (d_busy !== 1'b1 || d_rd !== 1'b1) begin errors++; $display("FAIL b2b_restart got %0d%0d want 11", d_busy, d_rd); end
    for (int c = 2; c <= 1000; c++) begin
      @(negedge clk); #1;
      if (d_done) begin at = c; break; end
    end
    checks++; if (at != 185) begin errors++; $display("FAIL b2b_second got %0d want 185", at); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stalls();
    test_random_stalls();
    test_ignored();
    test_wrap();
    test_p1();
    test_reset_mid_mac();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_pass_sequencer.md
# conv_pass_sequencer

Control FSM that sequences the CNN datapath of `P` parallel processing elements through a full convolution job. It:
- loads a 16-tap filter once per job;
- repeatedly fills each PE's 16-word window buffer from IFM memory;
- runs a broadcast 16-cycle MAC phase, then writes one OFM word per PE.

It sits between the job-level start/done interface and the datapath enables, replacing hand-wired enable sequencing with a counter-driven scheduler that tolerates variable-latency memory.

## Interface
- `P`, 4: number of PEs; power of two, 1..16.
- `N_WIN`, 8: output windows per job; multiple of `P`.
- `STRIDE`, 1: IFM address step between consecutive windows.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: job request; sampled in IDLE only.
- `done` output 1: one-cycle pulse at job end.
- `busy` output 1: high in every state except IDLE.
- `mem_rd` output 1: read request to IFM/filter memory.
- `mem_ack` input 1: read accepted and data valid in the same cycle.
- `ifm_addr` output 9: IFM read address.
- `filt_addr` output 9: filter read address.
- `ofm_addr` output 9: OFM write address.
- `elem_idx` output 4: buffer/tap index for the current phase.
- `filt_we` output 1: write filter buffer at `elem_idx`.
- `win_we` output P: one-hot write enable into PE window buffers.
- `mac_en` output 1: broadcast MAC step enable.
- `mac_rst` output 1: clear all PE accumulators.
- `ofm_write` output 1: write the selected PE result to OFM.
- `ofm_sel` output 4: PE whose result is written (`$clog2(P)` bits used).
- `stall_cycles` output 16: memory stall counter; see Configuration.

## Operation
- States: IDLE → LOAD_FILT → LOAD_WIN → MAC → WRITE → (LOAD_WIN | DONE) → IDLE.
- IDLE:
  - All strobes are 0.
  - `start`=1 → LOAD_FILT; the window counter `w`, PE counter `p` and `elem_idx` clear.
- LOAD_FILT:
  - `mem_rd`=1 and `filt_addr`=`elem_idx`.
  - On `mem_ack`: `filt_we`=1 combinationally in that cycle, then `elem_idx` increments.
  - The ack at `elem_idx`=15 → LOAD_WIN with `elem_idx`=0.
- LOAD_WIN:
  - `mem_rd`=1 and `ifm_addr`=`((w+p)·STRIDE + elem_idx) mod 512`.
  - On `mem_ack`: `win_we[p]`=1, then `elem_idx` increments.
  - After 16 acks: `p` increments. Once `p` has wrapped from P−1 → MAC.
  - `mac_rst`=1 throughout LOAD_WIN.
- MAC:
  - `mac_en`=1 for exactly 16 cycles, with `elem_idx` running 0..15.
  - `mem_rd`=0; then → WRITE.
- WRITE:
  - P cycles; `ofm_write`=1, `ofm_sel`=0..P−1 and `ofm_addr`=`w+ofm_sel`.
  - Then `w` += P.
  - If `w`=`N_WIN` → DONE, else → LOAD_WIN.
- DONE: `done`=1 for one cycle → IDLE.
- Only one memory request is outstanding at a time. `mem_rd` holds with a stable address until acked.
- `mem_ack` is ignored while `mem_rd`=0.
- `start` while `busy` is ignored. `start` held high after DONE starts a new job from IDLE in the next cycle.
- Address arithmetic is 9-bit and wraps modulo 512 silently.

## Timing
- Reset value of every output is 0, including `stall_cycles`. State goes to IDLE and all counters clear immediately, asynchronously.
- Reset mid-job: abort with no `done` pulse. Accumulator contents are not guaranteed.
- All outputs except `filt_we`/`win_we` are registered state decodes. `filt_we`/`win_we` are `mem_rd & mem_ack` gated by state.
- With `mem_ack` tied high, cycle 0 is the edge sampling `start`:
  - `done` is high during cycle `T = 17 + (N_WIN/P)·(17P+16)`.
  - For the defaults, T=185.
- Each memory stall cycle extends T by exactly one.

## Configuration
- `CONV_PASS_SEQ_PERF_EN` defined:
  - `stall_cycles` counts cycles with `mem_rd`=1 and `mem_ack`=0.
  - It saturates at 0xFFFF and clears on `start` accepted in IDLE.
- Undefined: `stall_cycles` is tied to 0 and no counter logic is generated.

## Structure
- Shared package `cnn_pkg`:
  - the state enum;
  - `FILT_LEN`=16 and `ADDR_W`=9;
  - the `elem_idx` width.
- One sub-module, `mod_counter`: a parameterised modulus counter with `en`, synchronous clear and terminal-count output. It is instantiated for `elem_idx`, `p` and the write-phase index.

## Test plan
- Defaults with `mem_ack`=1 and a `start` pulse:
  - 16 `filt_we`, 64 `win_we` per pass and 16 `mac_en` per pass;
  - 8 `ofm_write` at `ofm_addr` 0..7;
  - `done` at cycle 185.
- Stalls: `mem_ack` low on every other request cycle during LOAD_WIN. The address must hold while unacked, `done` is delayed by 128, and with PERF_EN `stall_cycles`=128.
- Wrap-around: `STRIDE`=100 with `N_WIN`=8. Window 6 must read `ifm_addr` 600 mod 512 = 88..103.
- Ignored inputs: `start` pulsed while busy, and `mem_ack` pulsed during MAC. Neither may change the write count nor `done` timing.
- `rst_n` low in the middle of the MAC phase:
  - all outputs are 0 within the same cycle, with no `done`;
  - a following `start` completes a clean job in 185 cycles.
- `P`=1, `N_WIN`=2: `win_we`=1'b1 pulses 16 per pass, `ofm_write` occurs twice, and `done` is at cycle 83.
